// File: rtl/sw_affine_engine.sv
// Smith-Waterman local-alignment engine, affine gaps, saturating scores.
// Scans one DP cell per cycle and reports the best score and its position.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high
//   valid        in   load beat qualifier (used in IDLE/LOAD only)
//   data_ref     in   2-bit reference symbol (A=0 C=1 G=2 T=3)
//   data_query   in   2-bit query symbol, used on the first QUERY_LEN beats
//   match_score  in   added to the diagonal on a symbol match
//   mismatch_pen in   subtracted from the diagonal on a mismatch
//   gap_open     in   cost of the first gap symbol
//   gap_ext      in   cost of each further gap symbol
//   busy         out  job in progress (LOAD after first beat, CALC, DONE)
//   finish       out  one-cycle pulse, results valid
//   max          out  best local score
//   pos_ref      out  1-based reference index of the best cell (0 if none)
//   pos_query    out  1-based query index of the best cell (0 if none)

module sw_affine_engine #(
    parameter int REF_LEN         = 64,
    parameter int QUERY_LEN       = 32,
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_PEN       = 4,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [1:0]                 data_ref,
    input  logic [1:0]                 data_query,
    input  logic [WIDTH_PEN-1:0]       match_score,
    input  logic [WIDTH_PEN-1:0]       mismatch_pen,
    input  logic [WIDTH_PEN-1:0]       gap_open,
    input  logic [WIDTH_PEN-1:0]       gap_ext,
    output logic                       busy,
    output logic                       finish,
    output logic [WIDTH_SCORE-1:0]     max,
    output logic [WIDTH_POS_REF-1:0]   pos_ref,
    output logic [WIDTH_POS_QUERY-1:0] pos_query
);

    localparam int WI = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;
    localparam int WJ = (QUERY_LEN > 1) ? $clog2(QUERY_LEN) : 1;
    // Arithmetic width: one bit above the wider operand so a
    // saturating add can see its own overflow.
    localparam int WW =
        ((WIDTH_SCORE > WIDTH_PEN) ? WIDTH_SCORE : WIDTH_PEN) + 1;

    localparam logic [WIDTH_SCORE-1:0] SMAX   = '1;
    localparam logic [WI-1:0]          I_LAST = WI'(REF_LEN - 1);
    localparam logic [WJ-1:0]          J_LAST = WJ'(QUERY_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DONE
    } state_t;

    // ------------------------------------------------------------
    // Saturating helpers
    // ------------------------------------------------------------
    function automatic logic [WIDTH_SCORE-1:0] f_sat_add(
        input logic [WIDTH_SCORE-1:0] a,
        input logic [WIDTH_PEN-1:0]   b
    );
        logic [WW-1:0] s;
        s = WW'(a) + WW'(b);
        if (s > WW'(SMAX))
            return SMAX;
        return s[WIDTH_SCORE-1:0];
    endfunction

    function automatic logic [WIDTH_SCORE-1:0] f_sat_sub(
        input logic [WIDTH_SCORE-1:0] a,
        input logic [WIDTH_PEN-1:0]   b
    );
        if (WW'(a) > WW'(b))
            return WIDTH_SCORE'(WW'(a) - WW'(b));
        return '0;
    endfunction

    function automatic logic [WIDTH_SCORE-1:0] f_max2(
        input logic [WIDTH_SCORE-1:0] a,
        input logic [WIDTH_SCORE-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // ------------------------------------------------------------
    // State
    // ------------------------------------------------------------
    state_t                   r_state;
    logic [WI-1:0]            r_cnt;
    logic [WI-1:0]            r_i;
    logic [WJ-1:0]            r_j;

    logic [WIDTH_PEN-1:0]     r_match;
    logic [WIDTH_PEN-1:0]     r_mis;
    logic [WIDTH_PEN-1:0]     r_gopen;
    logic [WIDTH_PEN-1:0]     r_gext;

    logic [WIDTH_SCORE-1:0]   r_hleft;
    logic [WIDTH_SCORE-1:0]   r_eleft;
    logic [WIDTH_SCORE-1:0]   r_hdiag;

    logic [WIDTH_SCORE-1:0]   r_best;
    logic [WIDTH_POS_REF-1:0] r_bi;
    logic [WIDTH_POS_QUERY-1:0] r_bj;

    logic [1:0]               r_ref   [REF_LEN];
    logic [1:0]               r_query [QUERY_LEN];
    logic [WIDTH_SCORE-1:0]   r_hrow  [QUERY_LEN];
    logic [WIDTH_SCORE-1:0]   r_frow  [QUERY_LEN];

    // ------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------
    logic w_beat;
    logic w_wr_q;

    assign w_beat = valid &&
                    ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_wr_q = (int'(r_cnt) < QUERY_LEN);

    // ------------------------------------------------------------
    // Cell datapath: H(i,j), E(i,j), F(i,j) for the current (r_i, r_j)
    // ------------------------------------------------------------
    logic [WIDTH_SCORE-1:0]     w_hup;
    logic [WIDTH_SCORE-1:0]     w_fup;
    logic [WIDTH_SCORE-1:0]     w_hl;
    logic [WIDTH_SCORE-1:0]     w_el;
    logic [WIDTH_SCORE-1:0]     w_hd;
    logic [WIDTH_SCORE-1:0]     w_e;
    logic [WIDTH_SCORE-1:0]     w_f;
    logic [WIDTH_SCORE-1:0]     w_d;
    logic [WIDTH_SCORE-1:0]     w_h;
    logic                       w_match;
    logic                       w_better;
    logic                       w_last;
    logic [WIDTH_POS_REF-1:0]   w_pi;
    logic [WIDTH_POS_QUERY-1:0] w_pj;

    // Row 1 sees a zero row above; column 1 sees zero left and
    // diagonal, so stale buffer contents never leak into a new job.
    assign w_hup = (r_i == '0) ? '0 : r_hrow[r_j];
    assign w_fup = (r_i == '0) ? '0 : r_frow[r_j];
    assign w_hl  = (r_j == '0) ? '0 : r_hleft;
    assign w_el  = (r_j == '0) ? '0 : r_eleft;
    assign w_hd  = (r_j == '0) ? '0 : r_hdiag;

    assign w_e = f_max2(f_sat_sub(w_hl, r_gopen),
                        f_sat_sub(w_el, r_gext));
    assign w_f = f_max2(f_sat_sub(w_hup, r_gopen),
                        f_sat_sub(w_fup, r_gext));

    assign w_match = (r_ref[r_i] == r_query[r_j]);
    assign w_d     = w_match ? f_sat_add(w_hd, r_match)
                             : f_sat_sub(w_hd, r_mis);

    // Unsigned values are never below 0, so the 0 term is implicit.
    assign w_h = f_max2(w_d, f_max2(w_e, w_f));

    // Strictly greater keeps the earliest cell on ties.
    assign w_better = (w_h > r_best);
    assign w_last   = (r_i == I_LAST) && (r_j == J_LAST);
    assign w_pi     = WIDTH_POS_REF'(r_i) + WIDTH_POS_REF'(1);
    assign w_pj     = WIDTH_POS_QUERY'(r_j) + WIDTH_POS_QUERY'(1);

    // ------------------------------------------------------------
    // Symbol and row buffers (no reset needed)
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_ref[r_cnt] <= data_ref;
            if (w_wr_q)
                r_query[r_cnt[WJ-1:0]] <= data_query;
        end
        if (r_state == S_CALC) begin
            r_hrow[r_j] <= w_h;
            r_frow[r_j] <= w_f;
        end
    end

    // ------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_match   <= '0;
            r_mis     <= '0;
            r_gopen   <= '0;
            r_gext    <= '0;
            r_hleft   <= '0;
            r_eleft   <= '0;
            r_hdiag   <= '0;
            r_best    <= '0;
            r_bi      <= '0;
            r_bj      <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            max       <= '0;
            pos_ref   <= '0;
            pos_query <= '0;
        end else begin
            finish <= 1'b0;
            unique case (r_state)
                S_IDLE, S_LOAD: begin
                    if (valid) begin
                        if (r_state == S_IDLE) begin
                            r_match <= match_score;
                            r_mis   <= mismatch_pen;
                            r_gopen <= gap_open;
                            r_gext  <= gap_ext;
                            r_best  <= '0;
                            r_bi    <= '0;
                            r_bj    <= '0;
                            r_i     <= '0;
                            r_j     <= '0;
                            busy    <= 1'b1;
                        end
                        if (r_cnt == I_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end

                S_CALC: begin
                    r_hleft <= w_h;
                    r_eleft <= w_e;
                    // H(i-1,j) becomes the diagonal of cell (i,j+1).
                    r_hdiag <= w_hup;
                    if (w_better) begin
                        r_best <= w_h;
                        r_bi   <= w_pi;
                        r_bj   <= w_pj;
                    end
                    if (r_j == J_LAST) begin
                        r_j <= '0;
                        if (r_i == I_LAST)
                            r_i <= '0;
                        else
                            r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                    // Publish including the final cell's contribution.
                    if (w_last) begin
                        r_state   <= S_DONE;
                        finish    <= 1'b1;
                        max       <= w_better ? w_h  : r_best;
                        pos_ref   <= w_better ? w_pi : r_bi;
                        pos_query <= w_better ? w_pj : r_bj;
                    end
                end

                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_affine_engine.sv
// Scoreboard bench for sw_affine_engine (REF_LEN=8, QUERY_LEN=4, 4-bit score).
// Stimulus pushes hand-computed results; a negedge monitor pops on finish.

module tb_sw_affine_engine;

    localparam int RL  = 8;
    localparam int QL  = 4;
    localparam int WS  = 4;
    localparam int WP  = 4;
    localparam int WPR = 4;
    localparam int WPQ = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           valid = 1'b0;
    logic [1:0]     data_ref = '0;
    logic [1:0]     data_query = '0;
    logic [WP-1:0]  match_score = '0;
    logic [WP-1:0]  mismatch_pen = '0;
    logic [WP-1:0]  gap_open = '0;
    logic [WP-1:0]  gap_ext = '0;
    logic           busy;
    logic           finish;
    logic [WS-1:0]  max;
    logic [WPR-1:0] pos_ref;
    logic [WPQ-1:0] pos_query;

    sw_affine_engine #(
        .REF_LEN(RL),
        .QUERY_LEN(QL),
        .WIDTH_SCORE(WS),
        .WIDTH_PEN(WP),
        .WIDTH_POS_REF(WPR),
        .WIDTH_POS_QUERY(WPQ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid(valid),
        .data_ref(data_ref),
        .data_query(data_query),
        .match_score(match_score),
        .mismatch_pen(mismatch_pen),
        .gap_open(gap_open),
        .gap_ext(gap_ext),
        .busy(busy),
        .finish(finish),
        .max(max),
        .pos_ref(pos_ref),
        .pos_query(pos_query)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int fin_cnt = 0;
    bit prev_fin = 1'b0;

    typedef struct {
        int    mx;
        int    pr;
        int    pq;
        int    cyc;
        string tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: one pop per finish pulse, plus pulse-width check.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (prev_fin)
                chk("finish_one_cycle", 32'(finish), 32'd0);
            if (finish === 1'b1) begin
                fin_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_finish: got pulse at cycle %0d expected none",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_max"}, 32'(max), 32'(e.mx));
                    chk({e.tag, "_pos_ref"}, 32'(pos_ref), 32'(e.pr));
                    chk({e.tag, "_pos_query"}, 32'(pos_query), 32'(e.pq));
                    chk({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc));
                end
            end
        end
        prev_fin = (finish === 1'b1);
    end

    // Symbols are packed LSB-first: symbol k at bits [2k+1:2k].
    task automatic run_job(input string tag,
                           input logic [15:0] rv, input logic [7:0] qv,
                           input logic [3:0] ms, input logic [3:0] mp,
                           input logic [3:0] go, input logic [3:0] ge,
                           input bit stall, input bit push,
                           input int emx, input int epr, input int epq);
        exp_t e;
        match_score  = ms;
        mismatch_pen = mp;
        gap_open     = go;
        gap_ext      = ge;
        @(posedge clk);
        #1;
        for (int k = 0; k < RL; k++) begin
            if (stall && k > 0) begin
                valid      = 1'b0;
                data_ref   = 2'($urandom);
                data_query = 2'($urandom);
                for (int s = 0; s < 2; s++) begin
                    @(posedge clk);
                    #1;
                    chk({tag, "_busy_stall"}, 32'(busy), 32'd1);
                end
            end
            valid      = 1'b1;
            data_ref   = rv[2*k +: 2];
            data_query = (k < QL) ? qv[2*k +: 2] : 2'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_busy_load"}, 32'(busy), 32'd1);
            if (stall && k == 0) begin
                match_score  = 4'($urandom);
                mismatch_pen = 4'($urandom);
                gap_open     = 4'($urandom);
                gap_ext      = 4'($urandom);
            end
        end
        valid = 1'b0;
        if (push) begin
            e.mx  = emx;
            e.pr  = epr;
            e.pq  = epq;
            e.cyc = cyc + RL * QL;
            e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int w = 0; w < 300 && sb.size() != 0; w++)
            @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no finish expected finish within 300 cycles",
                     tag);
            sb.delete();
        end
        @(posedge clk);
        #1;
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    int f0;

    initial begin
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_finish", 32'(finish), 32'd0);
        chk("reset_max", 32'(max), 32'd0);
        chk("reset_pos_ref", 32'(pos_ref), 32'd0);
        chk("reset_pos_query", 32'(pos_query), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ACGTACGT vs ACGT: 8 at (4,4); tie at (8,4) must not win.
        run_job("basic", 16'hE4E4, 8'hE4, 4'd2, 4'd1, 4'd3, 4'd1,
                1'b0, 1'b1, 8, 4, 4);
        wait_done("basic");

        // All A vs all T: empty alignment.
        run_job("nomatch", 16'h0000, 8'hFF, 4'd2, 4'd1, 4'd3, 4'd1,
                1'b0, 1'b1, 0, 0, 0);
        wait_done("nomatch");

        // ACGGTAAA vs ACGT: ACG-T with one gap, 16-3 = 13 at (5,4).
        run_job("affine", 16'h03A4, 8'hE4, 4'd4, 4'd1, 4'd3, 4'd1,
                1'b0, 1'b1, 13, 5, 4);
        wait_done("affine");

        // match 7 in a 4-bit score: 7, 14, then 15 saturates at (3,3).
        run_job("sat", 16'hE4E4, 8'hE4, 4'd7, 4'd1, 4'd3, 4'd1,
                1'b0, 1'b1, 15, 3, 3);
        wait_done("sat");

        // Stalled load with config ports scrambled after the first beat.
        run_job("stall", 16'hE4E4, 8'hE4, 4'd2, 4'd1, 4'd3, 4'd1,
                1'b1, 1'b1, 8, 4, 4);
        wait_done("stall");

        // Abort mid-CALC: outputs clear at once and no finish follows.
        run_job("abort", 16'hE4E4, 8'hE4, 4'd4, 4'd1, 4'd3, 4'd1,
                1'b0, 1'b0, 0, 0, 0);
        f0 = fin_cnt;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_finish", 32'(finish), 32'd0);
        chk("abort_max", 32'(max), 32'd0);
        chk("abort_pos_ref", 32'(pos_ref), 32'd0);
        chk("abort_pos_query", 32'(pos_query), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_finish", 32'(fin_cnt), 32'(f0));

        run_job("after_reset", 16'h03A4, 8'hE4, 4'd4, 4'd1, 4'd3, 4'd1,
                1'b0, 1'b1, 13, 5, 4);
        wait_done("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_affine_engine.md
Name: sw_affine_engine

Overview:
- Parametrised Smith-Waterman local-alignment engine over 2-bit nucleotide symbols (A=0, C=1, G=2, T=3).
- Adds the following over the fixed-size linear-gap SW core:
  - parametrised sequence lengths and score width
  - affine gap penalties
  - run-time programmable scoring
  - busy/stall-tolerant loading
  - saturating arithmetic
- Computes one DP cell per cycle. Reports the best local score and its 1-based (ref, query) cell position.

Parameters:
- REF_LEN, 64, reference symbols per job (REF_LEN >= QUERY_LEN >= 1).
- QUERY_LEN, 32, query symbols per job.
- WIDTH_SCORE, 8, score/H/E/F width, unsigned.
- WIDTH_PEN, 4, width of the scoring config ports.
- WIDTH_POS_REF, 7, pos_ref width (must hold REF_LEN).
- WIDTH_POS_QUERY, 6, pos_query width (must hold QUERY_LEN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- valid  in  1  load beat qualifier.
- data_ref  in  2  reference symbol.
- data_query  in  2  query symbol; used only on the first QUERY_LEN beats.
- match_score  in  WIDTH_PEN  added on a symbol match.
- mismatch_pen  in  WIDTH_PEN  subtracted on a mismatch.
- gap_open  in  WIDTH_PEN  cost of the first gap symbol.
- gap_ext  in  WIDTH_PEN  cost of each further gap symbol.
- busy  out  1  high in LOAD (after first beat), CALC and DONE.
- finish  out  1  one-cycle pulse; results valid.
- max  out  WIDTH_SCORE  best score.
- pos_ref  out  WIDTH_POS_REF  1-based ref index of best cell.
- pos_query  out  WIDTH_POS_QUERY  1-based query index of best cell.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - busy, finish, max, pos_ref, pos_query all = 0.
  - Buffers need not be cleared.
- State machine IDLE -> LOAD -> CALC -> DONE -> IDLE.
- IDLE:
  - First valid beat stores symbol 1, samples and holds the four config ports for the whole job, goes to LOAD.
  - max/pos keep the previous job's values until that beat.
- LOAD:
  - Each valid beat stores the next ref symbol, plus the query symbol while the query index is <= QUERY_LEN.
  - valid low stalls the load with no effect.
  - After beat REF_LEN, go to CALC.
  - valid is ignored outside IDLE/LOAD.
- CALC:
  - Row-major scan: i=1..REF_LEN (outer), j=1..QUERY_LEN (inner), one cell per cycle.
  - Exactly REF_LEN*QUERY_LEN cycles.
  - Row buffers hold H(i-1,*) and F(i-1,*); registers hold H(i,j-1), E(i,j-1) and the diagonal value.
  - Boundaries: H, E, F = 0 at i=0 or j=0.
  - All values are unsigned. Subtraction floors at 0; addition saturates at 2^WIDTH_SCORE-1.
  - Recurrences:
    - E(i,j)=max(H(i,j-1)-gap_open, E(i,j-1)-gap_ext)
    - F(i,j)=max(H(i-1,j)-gap_open, F(i-1,j)-gap_ext)
    - D = ref[i]==query[j] ? H(i-1,j-1)+match_score : H(i-1,j-1)-mismatch_pen
    - H(i,j)=max(0, D, E, F)
  - A gap of length k costs gap_open+(k-1)*gap_ext.
  - Best tracking:
    - update only when H is strictly greater than the running best, so ties keep the earliest cell in scan order.
    - running best is initialised to 0 with pos (0,0).
    - all-zero matrix -> max=0, pos_ref=0, pos_query=0.
- Timing: if the last load beat is cycle t, CALC occupies t+1..t+REF_LEN*QUERY_LEN. DONE is cycle t+REF_LEN*QUERY_LEN+1:
  - finish=1 for exactly this cycle.
  - max/pos are updated and held stable until the next job's first load beat.
- DONE -> IDLE unconditionally. A valid beat in the DONE cycle is dropped; the next job may start the following cycle.
- Reset mid-LOAD or mid-CALC aborts the job immediately: outputs return to 0, no finish pulse.

Test Plan:
- REF_LEN=8, QUERY_LEN=4, match 2 / mismatch 1 / open 3 / ext 1; ref 0,1,2,3,0,1,2,3, query 0,1,2,3 -> finish exactly 33 cycles after the last beat; max=8, pos_ref=4, pos_query=4 (tie at (8,4) rejected).
- Same config; ref all 0, query all 3 -> max=0, pos_ref=0, pos_query=0; finish pulses for one cycle only.
- Affine gap, match 4 / mismatch 1 / open 3 / ext 1; ref 0,1,2,2,3,0,0,0, query 0,1,2,3 -> max=13, pos_ref=5, pos_query=4.
- Saturation, WIDTH_SCORE=4, match 7, identical ACGT prefix -> max=15, pos_ref=3, pos_query=3 (later 15s rejected).
- Load stall: valid toggled 1,0,0,1,... during LOAD -> same results as the unstalled run; busy stays high throughout; finish is delayed only by the stall cycles.
- Assert reset midway through CALC -> busy, finish, max and pos all 0 at once, no finish pulse; a subsequent clean job gives the correct result.
